// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
// WIDTH-bit add/subtract built from one 4-bit slice that is stepped across
// the operands one nibble per clock. The carry/borrow is held in a flop
// between nibbles. START/BUSY/DONE handshake towards the sequencer.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for START; MODO decides RUN (add/sub) or FIN (nop/clear)
// RUN    | one nibble per edge; last nibble commits Q/RCO and goes to FIN
// FIN    | DONE pulse for exactly one cycle, then back to IDLE
//
// Operands are captured into shift registers and shifted right by one
// nibble per RUN edge, so the slice always reads bits [3:0]; the partial
// result is shifted in from the top, which leaves it aligned after NIB steps.
// Q/RCO live in their own registers so a partial or aborted run never
// disturbs the previously published result.

module nibble_serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             ABORT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             sub_q,    sub_d;
  logic             c_q,      c_d;
  logic [KW-1:0]    k_q,      k_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] q_q,      q_d;
  logic             rco_q,    rco_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [4:0]       slice_res;

  // 4-bit add/subtract slice on the low nibble of the captured operands;
  // bit 4 is the carry (add) or borrow (subtract, modulo-32 wrap).
  always_comb begin
    if (sub_q) begin
      slice_res = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, c_q};
    end else begin
      slice_res = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    c_d      = c_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    rco_d    = rco_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          case (MODO)
            OP_ADD, OP_SUB: begin
              a_d     = A;
              b_d     = B;
              sub_d   = MODO[1];
              c_d     = Cin;
              k_d     = '0;
              state_d = S_RUN;
              busy_d  = 1'b1;
            end
            OP_CLEAR: begin
              q_d     = '0;
              rco_d   = 1'b0;
              state_d = S_FIN;
              done_d  = 1'b1;
            end
            default: begin
              // OP_NOP: handshake only, result untouched
              state_d = S_FIN;
              done_d  = 1'b1;
            end
          endcase
        end
      end

      S_RUN: begin
        if (ABORT) begin
          // abort beats the last-nibble commit; published result untouched
          state_d = S_IDLE;
        end else begin
          a_d      = a_q >> 4;
          b_d      = b_q >> 4;
          c_d      = slice_res[4];
          k_d      = k_q + KW'(1);
          shadow_d = {slice_res[3:0], shadow_q[WIDTH-1:4]};
          if (k_q == K_LAST) begin
            q_d     = shadow_d;
            rco_d   = slice_res[4];
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            busy_d  = 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      c_q      <= 1'b0;
      k_q      <= '0;
      shadow_q <= '0;
      q_q      <= '0;
      rco_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      c_q      <= c_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      rco_q    <= rco_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Q    = q_q;
  assign RCO  = rco_q;

endmodule
